ksk_mgr_slot_scheduler: RTL

//  Allocates and sequences the KSK_SLOT_NB key-switch-key buffer slots of the ksk_manager.
//  - Grants free slots to batch load requests and issues load commands to the KSK loader.
//  - Tracks load completion and serves consumer lookups by batch id.
//  - Frees a slot once all CONSUMER_NB consumers have released it.

---
 rtl/ksk_mgr_slot_sched_pkg.sv | 20 ++
 rtl/ksk_mgr_slot_fsm.sv | 59 +++++
 rtl/ksk_mgr_slot_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ksk_mgr_slot_sched_pkg.sv
// rtl/ksk_mgr_slot_sched_pkg.sv - shared types and sizing for the KSK slot scheduler
package ksk_mgr_slot_sched_pkg;

    localparam int KSK_SLOT_NB = 8;
    localparam int CONSUMER_NB = 2;
    localparam int SLOT_W      = $clog2(KSK_SLOT_NB);
    localparam int REFCNT_W    = $clog2(CONSUMER_NB + 1);

    localparam int ERR_W         = 3;
    localparam int ERR_BAD_REL   = 0;
    localparam int ERR_BAD_DONE  = 1;
    localparam int ERR_DUP_ALLOC = 2;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } slot_state_e;

endpackage

// File: rtl/ksk_mgr_slot_fsm.sv
// rtl/ksk_mgr_slot_fsm.sv - per-slot lifecycle: FREE -> LOADING -> READY -> FREE
module ksk_mgr_slot_fsm
    import ksk_mgr_slot_sched_pkg::*;
#(
    parameter int BID_W = 8
) (
    input  logic                clk,
    input  logic                a_rst,
    input  logic                grant_i,
    input  logic [BID_W-1:0]    bid_i,
    input  logic                done_i,
    input  logic                rel_i,
    output slot_state_e         state_o,
    output logic [BID_W-1:0]    bid_o,
    output logic [REFCNT_W-1:0] refcnt_o
);

    slot_state_e         state_q;
    logic [BID_W-1:0]    bid_q;
    logic [REFCNT_W-1:0] refcnt_q;

    // Events that do not match the current state are dropped here; the top flags them.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q  <= FREE;
            bid_q    <= '0;
            refcnt_q <= '0;
        end else begin
            case (state_q)
                FREE: begin
                    if (grant_i) begin
                        state_q <= LOADING;
                        bid_q   <= bid_i;
                    end
                end
                LOADING: begin
                    if (done_i) begin
                        state_q  <= READY;
                        refcnt_q <= REFCNT_W'(CONSUMER_NB);
                    end
                end
                READY: begin
                    if (rel_i) begin
                        refcnt_q <= refcnt_q - REFCNT_W'(1);
                        if (refcnt_q == REFCNT_W'(1)) begin
                            state_q <= FREE;
                        end
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end

    assign state_o  = state_q;
    assign bid_o    = bid_q;
    assign refcnt_o = refcnt_q;

endmodule

// File: rtl/ksk_mgr_slot_scheduler.sv
// rtl/ksk_mgr_slot_scheduler.sv - allocates KSK buffer slots, issues loads, serves lookups and releases
module ksk_mgr_slot_scheduler
    import ksk_mgr_slot_sched_pkg::*;
#(
    parameter int BID_W = 8
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              alloc_vld,
    output logic              alloc_rdy,
    input  logic [BID_W-1:0]  alloc_bid,
    output logic              load_cmd_vld,
    input  logic              load_cmd_rdy,
    output logic [SLOT_W-1:0] load_cmd_slot,
    output logic [BID_W-1:0]  load_cmd_bid,
    input  logic              load_done_vld,
    input  logic [SLOT_W-1:0] load_done_slot,
    input  logic              rd_vld,
    output logic              rd_rdy,
    input  logic [BID_W-1:0]  rd_bid,
    output logic              rd_ack_vld,
    output logic [SLOT_W-1:0] rd_ack_slot,
    input  logic              rel_vld,
    input  logic [SLOT_W-1:0] rel_slot,
    output logic [SLOT_W:0]   free_cnt,
    output logic [ERR_W-1:0]  err
);

    slot_state_e         slot_st  [KSK_SLOT_NB];
    logic [BID_W-1:0]    slot_bid [KSK_SLOT_NB];
    logic [REFCNT_W-1:0] slot_ref [KSK_SLOT_NB];

    logic [KSK_SLOT_NB-1:0] grant_v, done_v, rel_v;

    logic              any_free, dup_hit, rd_hit, found_hi, rel_frees;
    logic [SLOT_W-1:0] pick_hi, pick_lo, pick_slot, rd_slot;
    logic              alloc_fire, grant;

    logic              load_cmd_vld_q;
    logic [SLOT_W-1:0] load_cmd_slot_q;
    logic [BID_W-1:0]  load_cmd_bid_q;
    logic              rd_ack_vld_q;
    logic [SLOT_W-1:0] rd_ack_slot_q;
    logic [SLOT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SLOT_W:0]   free_cnt_q, free_cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;

    for (genvar g = 0; g < KSK_SLOT_NB; g++) begin : g_slot
        ksk_mgr_slot_fsm #(.BID_W(BID_W)) u_slot (
            .clk      (clk),
            .a_rst    (a_rst),
            .grant_i  (grant_v[g]),
            .bid_i    (alloc_bid),
            .done_i   (done_v[g]),
            .rel_i    (rel_v[g]),
            .state_o  (slot_st[g]),
            .bid_o    (slot_bid[g]),
            .refcnt_o (slot_ref[g])
        );
    end

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        any_free  = 1'b0;
        dup_hit   = 1'b0;
        rd_hit    = 1'b0;
        rd_slot   = '0;
        found_hi  = 1'b0;
        pick_hi   = '0;
        pick_lo   = '0;
        rel_frees = 1'b0;
        done_v    = '0;
        rel_v     = '0;
        for (int i = KSK_SLOT_NB - 1; i >= 0; i--) begin
            if (slot_st[i] == FREE) begin
                any_free = 1'b1;
                pick_lo  = SLOT_W'(i);
                if (SLOT_W'(i) >= rr_ptr_q) begin
                    found_hi = 1'b1;
                    pick_hi  = SLOT_W'(i);
                end
            end else if (slot_bid[i] == alloc_bid) begin
                dup_hit = 1'b1;
            end
            if (slot_st[i] == READY && slot_bid[i] == rd_bid) begin
                rd_hit  = 1'b1;
                rd_slot = SLOT_W'(i);
            end
            if (load_done_vld && load_done_slot == SLOT_W'(i) && slot_st[i] == LOADING) begin
                done_v[i] = 1'b1;
            end
            if (rel_vld && rel_slot == SLOT_W'(i) && slot_st[i] == READY) begin
                rel_v[i] = 1'b1;
                if (slot_ref[i] == REFCNT_W'(1)) begin
                    rel_frees = 1'b1;
                end
            end
        end
    end

    assign pick_slot  = found_hi ? pick_hi : pick_lo;
    assign alloc_rdy  = any_free & (~load_cmd_vld_q | load_cmd_rdy);
    assign alloc_fire = alloc_vld & alloc_rdy;
    assign grant      = alloc_fire & ~dup_hit;

    always_comb begin
        grant_v = '0;
        if (grant) begin
            grant_v[pick_slot] = 1'b1;
        end
    end

    assign rr_ptr_d   = (pick_slot == SLOT_W'(KSK_SLOT_NB - 1)) ? '0 : pick_slot + SLOT_W'(1);
    assign free_cnt_d = free_cnt_q - (SLOT_W + 1)'(grant) + (SLOT_W + 1)'(rel_frees);

    always_comb begin
        err_d = err_q;
        if (alloc_fire && dup_hit)      err_d[ERR_DUP_ALLOC] = 1'b1;
        if (load_done_vld && !(|done_v)) err_d[ERR_BAD_DONE]  = 1'b1;
        if (rel_vld && !(|rel_v))        err_d[ERR_BAD_REL]   = 1'b1;
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            load_cmd_vld_q  <= 1'b0;
            load_cmd_slot_q <= '0;
            load_cmd_bid_q  <= '0;
            rd_ack_vld_q    <= 1'b0;
            rd_ack_slot_q   <= '0;
            rr_ptr_q        <= '0;
            free_cnt_q      <= (SLOT_W + 1)'(KSK_SLOT_NB);
            err_q           <= '0;
        end else begin
            if (grant) begin
                load_cmd_vld_q  <= 1'b1;
                load_cmd_slot_q <= pick_slot;
                load_cmd_bid_q  <= alloc_bid;
                rr_ptr_q        <= rr_ptr_d;
            end else if (load_cmd_rdy) begin
                load_cmd_vld_q  <= 1'b0;
            end
            rd_ack_vld_q <= rd_vld & rd_hit;
            if (rd_vld && rd_hit) begin
                rd_ack_slot_q <= rd_slot;
            end
            free_cnt_q <= free_cnt_d;
            err_q      <= err_d;
        end
    end

    assign load_cmd_vld  = load_cmd_vld_q;
    assign load_cmd_slot = load_cmd_slot_q;
    assign load_cmd_bid  = load_cmd_bid_q;
    assign rd_rdy        = rd_hit;
    assign rd_ack_vld    = rd_ack_vld_q;
    assign rd_ack_slot   = rd_ack_slot_q;
    assign free_cnt      = free_cnt_q;
    assign err           = err_q;

endmodule
